// File: rtl/logic_result_ser.sv
// Result serialiser: captures seven result bytes and streams them out
// over a valid/ready link, optionally followed by an XOR checksum byte.
module logic_result_ser #(
    parameter int CSUM_EN = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pi_start,
    input  logic [7:0] pi_c,
    input  logic [7:0] pi_d,
    input  logic [7:0] pi_e,
    input  logic [7:0] pi_f,
    input  logic [7:0] pi_g,
    input  logic [7:0] pi_h,
    input  logic [7:0] pi_i,
    input  logic       pi_ready,
    output logic [7:0] po_data,
    output logic       po_valid,
    output logic       po_last,
    output logic [2:0] po_cnt,
    output logic       po_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

    localparam logic NO_CSUM = (CSUM_EN == 0);

    state_t     r_state;
    logic [7:0] r_c, r_d, r_e, r_f, r_g, r_h, r_i;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_last;
    logic [2:0] r_cnt;
    logic       r_busy;

    logic       w_xfer;
    logic [7:0] w_csum;
    logic [7:0] w_next;

    assign w_xfer = r_valid & pi_ready;
    assign w_csum = r_c ^ r_d ^ r_e ^ r_f ^ r_g ^ r_h ^ r_i;

    // Byte that follows the one currently presented at r_cnt
    always_comb begin
        w_next = 8'h00;
        case (r_cnt)
            3'd0:    w_next = r_d;
            3'd1:    w_next = r_e;
            3'd2:    w_next = r_f;
            3'd3:    w_next = r_g;
            3'd4:    w_next = r_h;
            3'd5:    w_next = r_i;
            default: w_next = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_c     <= 8'h00;
            r_d     <= 8'h00;
            r_e     <= 8'h00;
            r_f     <= 8'h00;
            r_g     <= 8'h00;
            r_h     <= 8'h00;
            r_i     <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pi_start) begin
                        r_c     <= pi_c;
                        r_d     <= pi_d;
                        r_e     <= pi_e;
                        r_f     <= pi_f;
                        r_g     <= pi_g;
                        r_h     <= pi_h;
                        r_i     <= pi_i;
                        r_data  <= pi_c;
                        r_cnt   <= 3'd0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= 1'b0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (r_cnt == 3'd6) begin
                            if (!NO_CSUM) begin
                                r_state <= CSUM;
                                r_cnt   <= 3'd7;
                                r_data  <= w_csum;
                                r_last  <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_cnt   <= 3'd0;
                                r_data  <= 8'h00;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt  <= r_cnt + 3'd1;
                            r_data <= w_next;
                            r_last <= NO_CSUM && (r_cnt == 3'd5);
                        end
                    end
                end
                CSUM: begin
                    if (w_xfer) begin
                        r_state <= IDLE;
                        r_cnt   <= 3'd0;
                        r_data  <= 8'h00;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign po_data  = r_data;
    assign po_valid = r_valid;
    assign po_last  = r_last;
    assign po_cnt   = r_cnt;
    assign po_busy  = r_busy;

endmodule

// File: tb/tb_logic_result_ser.sv
// Directed bench for logic_result_ser; u0 has the checksum, u1 does not.
module tb_logic_result_ser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] c, d, e, f, g, h, i;

    logic [7:0] d0, d1;
    logic       v0, v1, l0, l1, b0, b1;
    logic [2:0] n0, n1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp [0:7];

    always #5 clk = ~clk;

    logic_result_ser #(.CSUM_EN(1)) u0 (
        .sys_clk(clk), .sys_rst(rst), .pi_start(start),
        .pi_c(c), .pi_d(d), .pi_e(e), .pi_f(f),
        .pi_g(g), .pi_h(h), .pi_i(i), .pi_ready(ready),
        .po_data(d0), .po_valid(v0), .po_last(l0),
        .po_cnt(n0), .po_busy(b0)
    );

    logic_result_ser #(.CSUM_EN(0)) u1 (
        .sys_clk(clk), .sys_rst(rst), .pi_start(start),
        .pi_c(c), .pi_d(d), .pi_e(e), .pi_f(f),
        .pi_g(g), .pi_h(h), .pi_i(i), .pi_ready(ready),
        .po_data(d1), .po_valid(v1), .po_last(l1),
        .po_cnt(n1), .po_busy(b1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_walk;
        c = 8'h01; d = 8'h02; e = 8'h04; f = 8'h08;
        g = 8'h10; h = 8'h20; i = 8'h40;
        exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h04;
        exp[3] = 8'h08; exp[4] = 8'h10; exp[5] = 8'h20;
        exp[6] = 8'h40; exp[7] = 8'h7F;
    endtask

    task automatic set_all(input logic [7:0] v);
        c = v; d = v; e = v; f = v; g = v; h = v; i = v;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        set_walk();
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (v0 !== 1'b0 || b0 !== 1'b0 || l0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags0 r=%0d: v=%b b=%b l=%b want 000", r, v0, b0, l0);
            end
            checks++;
            if (d0 !== 8'h00 || n0 !== 3'd0) begin
                errors++;
                $display("FAIL reset_data0 r=%0d: data=%h cnt=%0d want 00/0", r, d0, n0);
            end
            checks++;
            if (v1 !== 1'b0 || b1 !== 1'b0 || d1 !== 8'h00 || n1 !== 3'd0) begin
                errors++;
                $display("FAIL reset_u1 r=%0d: v=%b b=%b data=%h cnt=%0d want idle", r, v1, b1, d1, n1);
            end
            rst = 1'b0;
            tick();
        end
    endtask

    task automatic test_basic;
        do_reset();
        set_walk();
        for (int fr = 0; fr < 2; fr++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (d0 !== exp[k] || n0 !== 3'(k)) begin
                    errors++;
                    $display("FAIL basic_data f=%0d k=%0d: data=%h cnt=%0d want %h/%0d", fr, k, d0, n0, exp[k], k);
                end
                checks++;
                if (v0 !== 1'b1 || b0 !== 1'b1 || l0 !== (k == 7)) begin
                    errors++;
                    $display("FAIL basic_flags f=%0d k=%0d: v=%b b=%b l=%b want 11%b", fr, k, v0, b0, l0, (k == 7));
                end
                checks++;
                if (k < 7) begin
                    if (d1 !== exp[k] || n1 !== 3'(k) || v1 !== 1'b1 || l1 !== (k == 6)) begin
                        errors++;
                        $display("FAIL nocsum k=%0d: data=%h cnt=%0d v=%b l=%b want %h/%0d/1/%b", k, d1, n1, v1, l1, exp[k], k, (k == 6));
                    end
                end else if (v1 !== 1'b0 || b1 !== 1'b0) begin
                    errors++;
                    $display("FAIL nocsum_end: v=%b b=%b want 0/0", v1, b1);
                end
                tick();
            end
            checks++;
            if (v0 !== 1'b0 || b0 !== 1'b0 || d0 !== 8'h00 || n0 !== 3'd0) begin
                errors++;
                $display("FAIL basic_end f=%0d: v=%b b=%b data=%h cnt=%0d want idle", fr, v0, b0, d0, n0);
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        set_walk();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (d0 !== exp[k] || n0 !== 3'(k)) begin
                errors++;
                $display("FAIL stall_data k=%0d: data=%h cnt=%0d want %h/%0d", k, d0, n0, exp[k], k);
            end
            if (k == 2) begin
                ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checks++;
                    if (d0 !== 8'h04 || n0 !== 3'd2 || v0 !== 1'b1 || l0 !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold s=%0d: data=%h cnt=%0d v=%b l=%b want 04/2/1/0", s, d0, n0, v0, l0);
                    end
                end
                ready = 1'b1;
            end
            tick();
        end
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: v=%b want 0", v0);
        end
    endtask

    task automatic test_no_restart;
        do_reset();
        set_walk();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (d0 !== exp[k] || n0 !== 3'(k) || l0 !== (k == 7)) begin
                errors++;
                $display("FAIL norestart k=%0d: data=%h cnt=%0d l=%b want %h/%0d/%b", k, d0, n0, l0, exp[k], k, (k == 7));
            end
            if (k == 3) begin
                set_all(8'hFF);
                start = 1'b1;
            end
            if (k == 7) start = 1'b1;
            tick();
            start = 1'b0;
        end
        checks++;
        if (v0 !== 1'b0 || b0 !== 1'b0) begin
            errors++;
            $display("FAIL norestart_last: v=%b b=%b want 0/0", v0, b0);
        end
        tick();
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL norestart_idle: v=%b want 0", v0);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_walk();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (d0 !== 8'h08 || n0 !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_pre: data=%h cnt=%0d want 08/3", d0, n0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (v0 !== 1'b0 || b0 !== 1'b0 || d0 !== 8'h00 || n0 !== 3'd0 || l0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: v=%b b=%b data=%h cnt=%0d l=%b want idle", v0, b0, d0, n0, l0);
        end
        repeat (2) tick();
        checks++;
        if (v0 !== 1'b0 || b0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_resume: v=%b b=%b want 0/0", v0, b0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (d0 !== exp[k] || n0 !== 3'(k) || v0 !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_frame k=%0d: data=%h cnt=%0d v=%b want %h/%0d/1", k, d0, n0, v0, exp[k], k);
            end
            tick();
        end
    endtask

    task automatic test_all_ff;
        do_reset();
        set_all(8'hFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (d0 !== 8'hFF || n0 !== 3'(k) || l0 !== (k == 7)) begin
                errors++;
                $display("FAIL allff k=%0d: data=%h cnt=%0d l=%b want FF/%0d/%b", k, d0, n0, l0, k, (k == 7));
            end
            if (k < 7) begin
                checks++;
                if (d1 !== 8'hFF || l1 !== (k == 6)) begin
                    errors++;
                    $display("FAIL allff_nocsum k=%0d: data=%h l=%b want FF/%b", k, d1, l1, (k == 6));
                end
            end
            tick();
        end
    endtask

    initial begin
        set_walk();
        test_reset();
        test_basic();
        test_stall();
        test_no_restart();
        test_reset_mid();
        test_all_ff();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
